// File: rtl/lane_shift_scheduler_pkg.sv
// Shared definitions for the lane shift scheduler.
//   - state_e     : scheduler FSM states
//   - SHIFT_*     : shiftselection codes driven to the lane registers
//   - level_limit : speed-counter limit for a game level (before lane scaling)
//   - LANE_DIV    : per-lane extra right-shift of the level limit
package lane_shift_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_GRANT = 2'd3
    } state_e;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;

    localparam int LIMIT_W = 25;

    // Lane i uses LANE_DIV[i % 4]; lanes 1 and 3 run two and four times faster.
    localparam int unsigned LANE_DIV [4] = '{0, 1, 0, 2};

    function automatic logic [LIMIT_W-1:0] level_limit(input logic [2:0] level);
        case (level)
            3'd1:       return 25'h1FFFFFF;
            3'd2:       return 25'h1E00000;
            3'd3:       return 25'h1800000;
            3'd4, 3'd5: return 25'h1000000;
            default:    return '0;
        endcase
    endfunction

endpackage

// File: rtl/lane_shift_scheduler_if.sv
// Control/status bundle between the game controller and the lane shift scheduler.
//   level_InBus        : game level 0..5 (6/7 read as 0)
//   pause_InHigh       : freeze speed counters, block grants
//   busy_InHigh        : shared shift datapath busy, block grants
//   shift_valid_Out    : one-cycle shift strobe
//   lane_select_OutBus : granted lane
//   shiftselection_Out : 11 hold, 10 right, 01 left
//   clear_OutLow       : active-low clear of the lane registers
//   pending_OutBus     : per-lane pending shift flags
//   overrun_OutHigh    : sticky lost-event flag
interface lane_shift_scheduler_if #(
    parameter int LANES = 4
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [2:0]       level_InBus;
    logic             pause_InHigh;
    logic             busy_InHigh;
    logic             shift_valid_Out;
    logic [LW-1:0]    lane_select_OutBus;
    logic [1:0]       shiftselection_Out;
    logic             clear_OutLow;
    logic [LANES-1:0] pending_OutBus;
    logic             overrun_OutHigh;

    modport master (
        output level_InBus, pause_InHigh, busy_InHigh,
        input  shift_valid_Out, lane_select_OutBus, shiftselection_Out,
        input  clear_OutLow, pending_OutBus, overrun_OutHigh
    );

    modport slave (
        input  level_InBus, pause_InHigh, busy_InHigh,
        output shift_valid_Out, lane_select_OutBus, shiftselection_Out,
        output clear_OutLow, pending_OutBus, overrun_OutHigh
    );
endinterface

// File: rtl/lane_speed_counter.sv
// Reloadable per-lane down-counter.
//   clk_i/rst_i : clock, asynchronous active-high reset
//   clear_i     : force count to 0
//   load_i      : load limit_i
//   run_i       : decrement; at 0 reload limit_i and pulse expire_o
//   limit_i     : reload value (period is limit_i + 1 cycles)
//   expire_o    : combinational, high in the cycle the count wraps
module lane_speed_counter #(
    parameter int CNT_WIDTH = 25
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 run_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 expire_o
);
    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d  = count_q;
        expire_o = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = limit_i;
        end else if (run_i) begin
            if (count_q == '0) begin
                count_d  = limit_i;
                expire_o = 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/lane_shift_scheduler.sv
// Lane shift scheduler: LANES background lanes each run a speed counter whose
// expiry raises a pending flag; a round-robin arbiter grants one pending lane
// at a time to the shared shift datapath with a one-cycle strobe.
//   SC_STATEMACHINEBACKG_CLOCK_50    : clock
//   SC_STATEMACHINEBACKG_RESET_InHigh: asynchronous active-high reset
//   bus                              : lane_shift_scheduler_if slave modport
module lane_shift_scheduler
    import lane_shift_scheduler_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int CNT_WIDTH = 25,
    parameter int DIV_SCALE = 0
) (
    input  logic                   SC_STATEMACHINEBACKG_CLOCK_50,
    input  logic                   SC_STATEMACHINEBACKG_RESET_InHigh,
    lane_shift_scheduler_if.slave  bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    state_e           state_q, state_d;
    logic [2:0]       level_reg_q, level_reg_d;
    logic [LW-1:0]    last_grant_q, last_grant_d;
    logic [LANES-1:0] pending_q, pending_d;
    logic             overrun_q, overrun_d;

    logic [2:0]           eff_level;
    logic [LANES-1:0]     expire;
    logic                 run_en;
    logic [CNT_WIDTH-1:0] lane_limit [LANES];
    logic                 grant_found;
    logic [LW-1:0]        grant_sel;
    logic [LW-1:0]        rr_cand;

    assign eff_level = (bus.level_InBus > 3'd5) ? 3'd0 : bus.level_InBus;
    assign run_en    = ((state_q == S_RUN) || (state_q == S_GRANT)) && !bus.pause_InHigh;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int SHAMT = int'(LANE_DIV[i % 4]) + DIV_SCALE;

        assign lane_limit[i] = CNT_WIDTH'(level_limit(level_reg_q) >> SHAMT);

        lane_speed_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk_i   (SC_STATEMACHINEBACKG_CLOCK_50),
            .rst_i   (SC_STATEMACHINEBACKG_RESET_InHigh),
            .clear_i (state_q == S_IDLE),
            .load_i  (state_q == S_LOAD),
            .run_i   (run_en),
            .limit_i (lane_limit[i]),
            .expire_o(expire[i])
        );
    end

    // Round-robin: first pending lane strictly after last_grant, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_sel   = last_grant_q;
        rr_cand     = last_grant_q;
        for (int k = 1; k <= LANES; k++) begin
            rr_cand = LW'((int'(last_grant_q) + k) % LANES);
            if (!grant_found && pending_q[rr_cand]) begin
                grant_found = 1'b1;
                grant_sel   = rr_cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        level_reg_d  = level_reg_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (eff_level != 3'd0) begin
                    state_d     = S_LOAD;
                    level_reg_d = eff_level;
                end
            end
            S_LOAD: state_d = S_RUN;
            S_RUN, S_GRANT: begin
                // A level change wins over a new grant; a strobe already in
                // S_GRANT is still visible this cycle because outputs decode state_q.
                if (eff_level != level_reg_q) begin
                    level_reg_d = eff_level;
                    state_d     = (eff_level != 3'd0) ? S_LOAD : S_IDLE;
                end else if ((state_q == S_RUN) && grant_found &&
                             !bus.busy_InHigh && !bus.pause_InHigh) begin
                    state_d      = S_GRANT;
                    last_grant_d = grant_sel;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending/overrun: a grant clears its lane on exit, but an expiry of that
    // same lane in the grant cycle re-sets it without counting as overrun.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (state_q == S_LOAD) begin
            pending_d = '0;
            overrun_d = 1'b0;
        end else if ((state_q == S_RUN) || (state_q == S_GRANT)) begin
            for (int i = 0; i < LANES; i++) begin
                if (expire[i]) begin
                    if (pending_q[i] && !((state_q == S_GRANT) && (int'(last_grant_q) == i)))
                        overrun_d = 1'b1;
                    pending_d[i] = 1'b1;
                end else if ((state_q == S_GRANT) && (int'(last_grant_q) == i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        if (state_d == S_IDLE) pending_d = '0;
    end

    always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
        if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
            state_q      <= S_IDLE;
            level_reg_q  <= 3'd0;
            last_grant_q <= LW'(LANES - 1);
            pending_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_reg_q  <= level_reg_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
        end
    end

    // Outputs decode the state register directly so reset kills a strobe at once.
    assign bus.shift_valid_Out    = (state_q == S_GRANT);
    assign bus.lane_select_OutBus = last_grant_q;
    assign bus.shiftselection_Out = (state_q != S_GRANT) ? SHIFT_HOLD :
                                    (last_grant_q[0] ? SHIFT_LEFT : SHIFT_RIGHT);
    assign bus.clear_OutLow       = (state_q != S_IDLE);
    assign bus.pending_OutBus     = pending_q;
    assign bus.overrun_OutHigh    = overrun_q;
endmodule

// File: tb/tb_lane_shift_scheduler.sv
module tb_lane_shift_scheduler;
    localparam int LANES     = 4;
    localparam int CNT_WIDTH = 25;
    localparam int DIV_SCALE = 20;

    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_RUN = 2, PH_GRANT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lane_shift_scheduler_if #(.LANES(LANES)) bus ();

    lane_shift_scheduler #(
        .LANES(LANES), .CNT_WIDTH(CNT_WIDTH), .DIV_SCALE(DIV_SCALE)
    ) dut (
        .SC_STATEMACHINEBACKG_CLOCK_50    (clk),
        .SC_STATEMACHINEBACKG_RESET_InHigh(rst),
        .bus                              (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        int         lane;
        logic [1:0] sel;
        logic [3:0] pend;
        logic       ovr;
        logic       clr;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    bit   started = 0;
    bit   done = 0;

    // Reference model: phase, latched level, absolute expiry deadlines per lane.
    int         m_ph;
    int         m_lvl;
    longint     m_due [4];
    logic [3:0] m_pend;
    logic       m_ovr;
    int         m_last;
    longint     m_cyc = 0;

    function automatic int lim(input int lvl, input int lane);
        int base;
        int div;
        case (lvl)
            1:       base = 'h1FFFFFF;
            2:       base = 'h1E00000;
            3:       base = 'h1800000;
            4, 5:    base = 'h1000000;
            default: base = 0;
        endcase
        div = (lane == 1) ? 1 : (lane == 3) ? 2 : 0;
        return base >>> (div + DIV_SCALE);
    endfunction

    task automatic check(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) $display("FAIL %s: got %0d, required %0d", nm, act, req);
        else passes++;
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_lvl = 0; m_pend = '0; m_ovr = 1'b0; m_last = LANES - 1;
    endtask

    task automatic model_step(input int lvl_in, input bit p, input bit b, input bit r);
        int         eff;
        int         nph;
        logic [3:0] old;
        bit         ex;
        bit         gr;
        if (r) begin
            model_reset();
            m_cyc++;
            return;
        end
        eff = (lvl_in > 5) ? 0 : lvl_in;
        old = m_pend;
        nph = m_ph;
        if (m_ph == PH_IDLE) begin
            if (eff != 0) begin m_lvl = eff; nph = PH_LOAD; end
        end else if (m_ph == PH_LOAD) begin
            for (int i = 0; i < 4; i++) m_due[i] = m_cyc + 1 + lim(m_lvl, i);
            m_pend = '0; m_ovr = 1'b0; nph = PH_RUN;
        end else begin
            for (int i = 0; i < 4; i++) begin
                ex = !p && (m_due[i] == m_cyc);
                gr = (m_ph == PH_GRANT) && (m_last == i);
                if (p) m_due[i]++;
                else if (ex) m_due[i] = m_cyc + 1 + lim(m_lvl, i);
                if (ex) begin
                    if (old[i] && !gr) m_ovr = 1'b1;
                    m_pend[i] = 1'b1;
                end else if (gr) begin
                    m_pend[i] = 1'b0;
                end
            end
            if (eff != m_lvl) begin
                m_lvl = eff;
                nph = (eff != 0) ? PH_LOAD : PH_IDLE;
                if (nph == PH_IDLE) m_pend = '0;
            end else if (m_ph == PH_RUN && old != 0 && !b && !p) begin
                for (int k = 1; k <= 4; k++) begin
                    if (old[(m_last + k) % 4]) begin
                        m_last = (m_last + k) % 4;
                        break;
                    end
                end
                nph = PH_GRANT;
            end else begin
                nph = PH_RUN;
            end
        end
        m_ph = nph;
        m_cyc++;
    endtask

    task automatic push_exp();
        exp_t e;
        e.vld  = (m_ph == PH_GRANT);
        e.lane = m_last;
        e.sel  = !e.vld ? 2'b11 : ((m_last % 2) != 0 ? 2'b01 : 2'b10);
        e.pend = m_pend;
        e.ovr  = m_ovr;
        e.clr  = (m_ph != PH_IDLE);
        sbq.push_back(e);
        started = 1;
    endtask

    task automatic tick(input int lvl, input bit p, input bit b, input bit r);
        @(negedge clk);
        rst = r;
        bus.level_InBus  = 3'(lvl);
        bus.pause_InHigh = p;
        bus.busy_InHigh  = b;
        model_step(lvl, p, b, r);
        push_exp();
    endtask

    // Monitor: pops one expected snapshot per cycle just after the clock edge.
    initial begin : monitor
        exp_t   e;
        longint mon_cyc = 0;
        longint load_cyc = 0;
        bit     prev_clr = 0;
        bit     armed = 0;
        bit     lat_done = 0;
        forever begin
            @(posedge clk);
            #2;
            if (done) break;
            mon_cyc++;
            if (bus.clear_OutLow && !prev_clr && !lat_done) begin
                load_cyc = mon_cyc;
                armed = 1;
            end
            prev_clr = bus.clear_OutLow;
            if (armed && bus.shift_valid_Out) begin
                check("first_strobe_latency", mon_cyc - load_cyc, 10);
                check("first_strobe_lane", longint'(bus.lane_select_OutBus), 3);
                check("first_strobe_sel", longint'(bus.shiftselection_Out), 1);
                armed = 0;
                lat_done = 1;
            end
            if (sbq.size() == 0) begin
                if (started) begin
                    checks++;
                    $display("FAIL scoreboard_underflow: got empty queue, required one entry");
                end
                continue;
            end
            e = sbq.pop_front();
            checks++;
            if (bus.shift_valid_Out !== e.vld || int'(bus.lane_select_OutBus) != e.lane ||
                bus.shiftselection_Out !== e.sel || bus.pending_OutBus !== e.pend ||
                bus.overrun_OutHigh !== e.ovr || bus.clear_OutLow !== e.clr) begin
                $display("FAIL cycle_outputs t=%0t: got vld=%b lane=%0d sel=%b pend=%b ovr=%b clr=%b, required vld=%b lane=%0d sel=%b pend=%b ovr=%b clr=%b",
                         $time, bus.shift_valid_Out, bus.lane_select_OutBus, bus.shiftselection_Out,
                         bus.pending_OutBus, bus.overrun_OutHigh, bus.clear_OutLow,
                         e.vld, e.lane, e.sel, e.pend, e.ovr, e.clr);
            end else begin
                passes++;
            end
        end
    end

    initial begin : stimulus
        int  lv;
        bit  found;
        bus.level_InBus  = 3'd0;
        bus.pause_InHigh = 1'b0;
        bus.busy_InHigh  = 1'b0;
        model_reset();

        repeat (3) tick(0, 0, 0, 1);
        @(posedge clk); #1;
        check("reset_clear", bus.clear_OutLow, 0);
        check("reset_valid", bus.shift_valid_Out, 0);
        check("reset_sel", bus.shiftselection_Out, 3);
        check("reset_pending", bus.pending_OutBus, 0);
        check("reset_overrun", bus.overrun_OutHigh, 0);
        check("reset_lane", bus.lane_select_OutBus, LANES - 1);

        repeat (4) tick(0, 0, 0, 0);
        repeat (60) tick(1, 0, 0, 0);

        repeat (20) tick(1, 0, 1, 0);
        @(posedge clk); #1;
        check("busy_overrun", bus.overrun_OutHigh, 1);
        check("busy_no_strobe", bus.shift_valid_Out, 0);
        repeat (40) tick(1, 0, 0, 0);

        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            tick(1, 0, 0, 0);
            if (m_pend != 0 && m_ph == PH_RUN) found = 1;
        end
        check("pending_wait", found, 1);
        tick(3, 0, 0, 0);
        tick(3, 0, 0, 0);
        @(posedge clk); #1;
        check("relevel_pending", bus.pending_OutBus, 0);
        check("relevel_overrun", bus.overrun_OutHigh, 0);
        check("relevel_clear", bus.clear_OutLow, 1);
        repeat (60) tick(3, 0, 0, 0);

        lv = 2;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(59) == 0) lv = int'($urandom_range(7));
            tick(lv, $urandom_range(99) < 8, $urandom_range(99) < 30, 0);
        end

        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            tick(2, 0, 0, 0);
            if (m_ph == PH_GRANT) found = 1;
        end
        check("grant_wait", found, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_grant_valid", bus.shift_valid_Out, 0);
        check("rst_grant_clear", bus.clear_OutLow, 0);
        check("rst_grant_pending", bus.pending_OutBus, 0);
        model_reset();
        repeat (2) tick(2, 0, 0, 1);
        repeat (40) tick(2, 0, 0, 0);

        repeat (5) tick(6, 0, 0, 0);
        @(posedge clk); #1;
        check("level6_clear", bus.clear_OutLow, 0);
        check("level6_valid", bus.shift_valid_Out, 0);
        check("level6_pending", bus.pending_OutBus, 0);
        repeat (3) tick(7, 0, 0, 0);
        repeat (30) tick(1, 0, 0, 0);

        @(posedge clk); #4;
        done = 1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
